// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared state encoding, digit width and defaults for the count game controller
package count_pkg;

    localparam int BCD_W         = 4;
    localparam int DEF_CLK_HZ    = 1000;
    localparam int DEF_START_SEC = 30;
    localparam int DEF_ALARM_MAX = 2000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_ALARM = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Packs a 0..99 value into {tens, ones} BCD digits.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - CLK_HZ prescaler producing a one-cycle tick per second
module sec_tick #(
    parameter int CLK_HZ = count_pkg::DEF_CLK_HZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick fires on the edge that wraps the counter; clear takes priority.
    assign tick = en & ~clr & (cnt_q == TC);

    // Next prescaler value: clear, hold, or count 0..CLK_HZ-1 and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - countdown game FSM with BCD seconds and alarm watchdog; COUNT_CTRL_PAUSE_EN enables pause
module count_ctrl
    import count_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int START_SEC = DEF_START_SEC,
    parameter int ALARM_MAX = DEF_ALARM_MAX
) (
    input  logic             clk,
    input  logic             st,
    input  logic             key_start,
    input  logic             key_pause,
    input  logic             beep_over,
    output logic             beep_st,
    output logic             running,
    output logic             done,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones
);

    localparam int WD_W = (ALARM_MAX > 1) ? $clog2(ALARM_MAX) : 1;
    localparam logic [WD_W-1:0] WD_TC = WD_W'(ALARM_MAX - 1);
    localparam logic [2*BCD_W-1:0] START_BCD = to_bcd(START_SEC);

    state_e           state_q, state_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             beep_st_q, beep_st_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             start_cur_q, start_prev_q;
    logic             start_edge;
    logic             pre_clr, pre_en, tick;

    assign start_edge = start_cur_q & ~start_prev_q;

`ifdef COUNT_CTRL_PAUSE_EN
    logic pause_cur_q, pause_prev_q;
    logic pause_edge;

    assign pause_edge = pause_cur_q & ~pause_prev_q;

    // Pause key history for rising-edge detection.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            pause_cur_q  <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            pause_cur_q  <= key_pause;
            pause_prev_q <= pause_cur_q;
        end
    end
`else
    logic pause_unused;
    assign pause_unused = key_pause;
`endif

    // Start key history for rising-edge detection.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            start_cur_q  <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_cur_q  <= key_start;
            start_prev_q <= start_cur_q;
        end
    end

    sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk   (clk),
        .rst_n (st),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    // Next-state, BCD countdown and watchdog; outputs follow the next state so they stay registered.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        wd_d    = '0;
        pre_clr = 1'b0;
        pre_en  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    tens_d  = START_BCD[2*BCD_W-1:BCD_W];
                    ones_d  = START_BCD[BCD_W-1:0];
                    pre_clr = 1'b1;
                    state_d = (START_SEC == 0) ? S_ALARM : S_RUN;
                end
            end
            S_RUN: begin
                pre_en = 1'b1;
`ifdef COUNT_CTRL_PAUSE_EN
                if (pause_edge) begin
                    state_d = S_PAUSE;
                end else
`endif
                if (tick) begin
                    if (tens_q == '0 && ones_q == BCD_W'(1)) begin
                        ones_d  = '0;
                        state_d = S_ALARM;
                    end else if (ones_q == '0) begin
                        ones_d = BCD_W'(9);
                        tens_d = tens_q - 1'b1;
                    end else begin
                        ones_d = ones_q - 1'b1;
                    end
                end
            end
`ifdef COUNT_CTRL_PAUSE_EN
            S_PAUSE: begin
                if (pause_edge) begin
                    state_d = S_RUN;
                end
            end
`endif
            S_ALARM: begin
                if (beep_over || wd_q == WD_TC) begin
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        beep_st_d = (state_d == S_ALARM);
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // State, digits, watchdog and registered outputs.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            state_q   <= S_IDLE;
            tens_q    <= START_BCD[2*BCD_W-1:BCD_W];
            ones_q    <= START_BCD[BCD_W-1:0];
            wd_q      <= '0;
            beep_st_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            wd_q      <= wd_d;
            beep_st_q <= beep_st_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign beep_st  = beep_st_q;
    assign running  = running_q;
    assign done     = done_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - scoreboard bench for count_ctrl with three start values sharing one random stimulus
module tb_count_ctrl;

    localparam int NDUT = 3;
    localparam int HZ   = 10;
    localparam int SS [NDUT] = '{3, 10, 0};
    localparam int AM [NDUT] = '{8, 20, 5};

`ifdef COUNT_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;
    localparam int M_DONE  = 4;

    logic clk = 1'b0;
    logic st = 1'b0;
    logic key_start = 1'b0;
    logic key_pause = 1'b0;
    logic beep_over = 1'b0;

    logic       beep_w [NDUT];
    logic       run_w  [NDUT];
    logic       done_w [NDUT];
    logic [3:0] tens_w [NDUT];
    logic [3:0] ones_w [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        count_ctrl #(
            .CLK_HZ    (HZ),
            .START_SEC (SS[g]),
            .ALARM_MAX (AM[g])
        ) u_dut (
            .clk       (clk),
            .st        (st),
            .key_start (key_start),
            .key_pause (key_pause),
            .beep_over (beep_over),
            .beep_st   (beep_w[g]),
            .running   (run_w[g]),
            .done      (done_w[g]),
            .sec_tens  (tens_w[g]),
            .sec_ones  (ones_w[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [10:0] exp_q [NDUT][$];

    // Reference model: mode, integer seconds, cycles elapsed in the current second, alarm age, key history.
    int m_mode [NDUT];
    int m_sec  [NDUT];
    int m_ph   [NDUT];
    int m_wd   [NDUT];
    bit m_s1 [NDUT], m_s2 [NDUT], m_p1 [NDUT], m_p2 [NDUT];

    function automatic logic [10:0] act_vec(input int d);
        return {run_w[d], done_w[d], beep_w[d], tens_w[d], ones_w[d]};
    endfunction

    function automatic logic [10:0] model_vec(input int d);
        return {m_mode[d] == M_RUN, m_mode[d] == M_DONE, m_mode[d] == M_ALARM,
                4'(m_sec[d] / 10), 4'(m_sec[d] % 10)};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got run/done/beep/tens/ones=%b/%b/%b/%0d/%0d required %b/%b/%b/%0d/%0d",
                      name, act[10], act[9], act[8], act[7:4], act[3:0],
                      exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
    endtask

    task automatic model_step(input int d, input logic s, input logic ks, input logic kp, input logic bo);
        bit sedge, pedge, tick;
        if (!s) begin
            m_mode[d] = M_IDLE;
            m_sec[d]  = SS[d];
            m_ph[d]   = 0;
            m_wd[d]   = 0;
            m_s1[d] = 0; m_s2[d] = 0; m_p1[d] = 0; m_p2[d] = 0;
        end else begin
            sedge = m_s1[d] && !m_s2[d];
            pedge = PAUSE_EN && m_p1[d] && !m_p2[d];
            m_s2[d] = m_s1[d]; m_s1[d] = ks;
            m_p2[d] = m_p1[d]; m_p1[d] = kp;
            case (m_mode[d])
                M_IDLE, M_DONE: if (sedge) begin
                    m_sec[d]  = SS[d];
                    m_ph[d]   = 0;
                    m_wd[d]   = 0;
                    m_mode[d] = (SS[d] == 0) ? M_ALARM : M_RUN;
                end
                M_RUN: begin
                    tick    = (m_ph[d] == HZ - 1);
                    m_ph[d] = (m_ph[d] + 1) % HZ;
                    if (pedge) m_mode[d] = M_PAUSE;
                    else if (tick) begin
                        m_sec[d]--;
                        if (m_sec[d] == 0) begin
                            m_mode[d] = M_ALARM;
                            m_wd[d]   = 0;
                        end
                    end
                end
                M_PAUSE: if (pedge) m_mode[d] = M_RUN;
                M_ALARM: begin
                    if (bo || m_wd[d] == AM[d] - 1) m_mode[d] = M_DONE;
                    else m_wd[d]++;
                end
                default: m_mode[d] = M_IDLE;
            endcase
        end
        exp_q[d].push_back(model_vec(d));
    endtask

    // Applies one cycle of inputs shortly after a rising edge and records what the next edge must produce.
    task automatic cycle(input logic s, input logic ks, input logic kp, input logic bo);
        logic fell;
        fell = st && !s;
        st = s; key_start = ks; key_pause = kp; beep_over = bo;
        if (fell) begin
            #1;
            for (int d = 0; d < NDUT; d++)
                check($sformatf("async_rst dut%0d t=%0t", d, $time), act_vec(d),
                      {3'b000, 4'(SS[d] / 10), 4'(SS[d] % 10)});
        end
        for (int d = 0; d < NDUT; d++) model_step(d, s, ks, kp, bo);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n, input logic ks, input logic kp, input logic bo);
        for (int i = 0; i < n; i++) cycle(1'b1, ks, kp, bo);
    endtask

    // Monitor: after every edge, compare each design against the oldest pending expectation.
    always @(posedge clk) begin
        logic [10:0] e;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (exp_q[d].size() != 0) begin
                e = exp_q[d].pop_front();
                check($sformatf("dut%0d t=%0t", d, $time), act_vec(d), e);
            end
        end
    end

    initial begin
        logic ks, kp, bo, s;
        @(posedge clk);
        #2;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        hold(2, 0, 0, 0);
        // Full countdown ending on the watchdog.
        hold(3, 1, 0, 0);
        hold(125, 0, 0, 0);
        // Countdown ending on beep_over.
        hold(3, 1, 0, 0);
        hold(110, 0, 0, 1);
        // Pause partway through a second, long hold, resume.
        hold(3, 1, 0, 0);
        hold(12, 0, 0, 0);
        hold(3, 0, 1, 0);
        hold(50, 0, 0, 0);
        hold(3, 0, 1, 0);
        hold(30, 0, 0, 1);
        // Reset while the short design is in ALARM and the long one is running.
        hold(3, 1, 0, 0);
        hold(33, 0, 0, 0);
        cycle(1'b0, 0, 0, 0);
        cycle(1'b0, 0, 0, 0);
        hold(3, 0, 0, 0);
        // Randomized keys, beep_over and occasional resets.
        ks = 0; kp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ks = ~ks;
            if ($urandom_range(0, 19) == 0) kp = ~kp;
            bo = ($urandom_range(0, 5) == 0);
            s  = ($urandom_range(0, 299) != 0);
            cycle(s, ks, kp, bo);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
